// File: rtl/mux_arbiter_defs.sv
// Shared encodings for the two-requester mux arbiter: FSM state codes and requester indices.
package mux_arbiter_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mux_arbiter_2.sv
// Round-robin owner of a shared 2:1 mux with a bounded hold under contention.
// Optional grant-event counters are built when MUX_ARBITER_STATS_EN is defined.
//
// state  | meaning
// IDLE   | nobody owns the mux, output floats (enable=1)
// GRANT0 | requester 0 drives the mux (select=0)
// GRANT1 | requester 1 drives the mux (select=1)
module mux_arbiter_2
  import mux_arbiter_defs::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic select,
  output logic enable,
  output logic busy
`ifdef MUX_ARBITER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] gnt_cnt0,
  output logic [STAT_WIDTH-1:0] gnt_cnt1
`endif
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_WIDTH) - 1 || STAT_WIDTH < 1) begin : g_bad_cfg
    $error("mux_arbiter_2: illegal parameter set");
  end

  arb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 last_q, last_d;
  logic                 select_d;
  logic                 other_req;

  always_comb begin
    state_d   = state_q;
    other_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = (last_q == REQ0) ? GRANT1 : GRANT0;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0: begin
        other_req = req1;
        if (!req0 && req1)                     state_d = GRANT1;
        else if (!req0)                        state_d = IDLE;
        else if (req1 && hold_q == HOLD_LAST)  state_d = GRANT1;
      end
      GRANT1: begin
        other_req = req0;
        if (!req1 && req0)                     state_d = GRANT0;
        else if (!req1)                        state_d = IDLE;
        else if (req0 && hold_q == HOLD_LAST)  state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    // The counter only runs while the same owner keeps the mux against a waiting peer.
    if (state_d != state_q || !other_req) hold_d = '0;
    else                                  hold_d = hold_q + CNT_WIDTH'(1);

    last_d   = last_q;
    select_d = select;
    if (state_d == GRANT0) begin
      last_d   = REQ0;
      select_d = 1'b0;
    end else if (state_d == GRANT1) begin
      last_d   = REQ1;
      select_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= REQ1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      select  <= 1'b0;
      enable  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt0    <= (state_d == GRANT0);
      gnt1    <= (state_d == GRANT1);
      select  <= select_d;
      enable  <= (state_d == IDLE);
      busy    <= (state_d != IDLE);
    end
  end

`ifdef MUX_ARBITER_STATS_EN
  sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_d == GRANT0) && (state_q != GRANT0)),
    .count (gnt_cnt0)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_d == GRANT1) && (state_q != GRANT1)),
    .count (gnt_cnt1)
  );
`endif

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Directed bench for mux_arbiter_2 (MAX_HOLD=8 and MAX_HOLD=1 instances);
// stats checks are included when MUX_ARBITER_STATS_EN is defined.
module tb_mux_arbiter_2;

  logic clk = 1'b0;
  logic rst_n, req0, req1, b_req0, b_req1;
  logic gnt0, gnt1, select, enable, busy;
  logic b_gnt0, b_gnt1, b_select, b_enable, b_busy;
`ifdef MUX_ARBITER_STATS_EN
  logic [1:0] gnt_cnt0, gnt_cnt1, b_cnt0, b_cnt1;
`endif

  int nvec = 0;
  int nerr = 0;

  // {gnt0, gnt1, select, enable, busy}
  localparam logic [4:0] O_RST   = 5'b00010;
  localparam logic [4:0] O_G0    = 5'b10001;
  localparam logic [4:0] O_G1    = 5'b01101;
  localparam logic [4:0] O_IDLE1 = 5'b00110;

  always #5 clk = ~clk;

  mux_arbiter_2 #(.MAX_HOLD(8), .CNT_WIDTH(4), .STAT_WIDTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .select(select), .enable(enable), .busy(busy)
`ifdef MUX_ARBITER_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  mux_arbiter_2 #(.MAX_HOLD(1), .CNT_WIDTH(4), .STAT_WIDTH(2)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .req0(b_req0), .req1(b_req1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .select(b_select), .enable(b_enable), .busy(b_busy)
`ifdef MUX_ARBITER_STATS_EN
    , .gnt_cnt0(b_cnt0), .gnt_cnt1(b_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input string tag, input logic [4:0] exp);
    @(posedge clk); #1;
    chk(tag, {27'd0, gnt0, gnt1, select, enable, busy}, {27'd0, exp});
  endtask

  task automatic step_b(input string tag, input logic [4:0] exp);
    @(posedge clk); #1;
    chk(tag, {27'd0, b_gnt0, b_gnt1, b_select, b_enable, b_busy}, {27'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; b_req0 = 1'b0; b_req1 = 1'b0;

    step_a("reset_c1", O_RST);
    step_a("reset_c2", O_RST);
    rst_n = 1'b1;

    // Contention: 8 cycles each, alternating, starting with req0.
    for (int k = 0; k < 20; k++)
      step_a("contend", ((k / 8) % 2 == 0) ? O_G0 : O_G1);

    // Owner 0 (hold=3) drops; owner 1 takes over with no bubble and a fresh hold budget.
    req0 = 1'b0;
    step_a("handover", O_G1);
    req0 = 1'b1;
    for (int j = 1; j < 8; j++) step_a("hold_restart", O_G1);
    step_a("hold_restart_preempt", O_G0);

    // Drive into GRANT1 with hold_cnt=5, then reset for one edge.
    req0 = 1'b0;
    step_a("to_g1", O_G1);
    req0 = 1'b1;
    for (int j = 1; j <= 5; j++) step_a("g1_hold", O_G1);
    rst_n = 1'b0;
    step_a("reset_mid_grant", O_RST);
    rst_n = 1'b1;
    step_a("post_reset_tie", O_G0);

    req0 = 1'b0; req1 = 1'b0;
    step_a("to_idle_sel0", O_RST);
    req1 = 1'b1;
    for (int j = 0; j < 5; j++) step_a("single_req1", O_G1);
    req1 = 1'b0;
    step_a("idle_keeps_sel1", O_IDLE1);
    step_a("idle_stays", O_IDLE1);

    req0 = 1'b1;
    step_a("pulse_grant", O_G0);
    req0 = 1'b0;
    step_a("pulse_release", O_RST);

    // Last owner was 0, so the next tie goes to requester 1.
    req0 = 1'b1; req1 = 1'b1;
    step_a("rr_tie_to_1", O_G1);
    req0 = 1'b0; req1 = 1'b0;
    step_a("rr_idle", O_IDLE1);

    // MAX_HOLD=1: ownership alternates every cycle.
    b_req0 = 1'b1; b_req1 = 1'b1;
    for (int j = 0; j < 6; j++) step_b("maxhold1_alt", (j % 2 == 0) ? O_G0 : O_G1);
    b_req0 = 1'b0; b_req1 = 1'b0;

`ifdef MUX_ARBITER_STATS_EN
    rst_n = 1'b0;
    step_a("stats_reset", O_RST);
    chk("stats_cnt0_reset", {30'd0, gnt_cnt0}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0 = 1'b1;
      step_a("stats_burst", O_G0);
      chk("stats_cnt0", {30'd0, gnt_cnt0}, (i < 2) ? i + 1 : 3);
      step_a("stats_burst_hold", O_G0);
      chk("stats_cnt0_hold", {30'd0, gnt_cnt0}, (i < 2) ? i + 1 : 3);
      req0 = 1'b0;
      step_a("stats_gap", O_RST);
    end
    chk("stats_cnt1", {30'd0, gnt_cnt1}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
